// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL manager: Get/Put (and optional atomics under TL_RESP_ATOMICS_EN) served from a word array.
// Latency: 1 cycle from A accept to D valid; responses leave in acceptance order via a 2-entry queue.
// Backpressure: a_ready = queue not full, from registered count only; d_ready low stalls the queue.
`timescale 1ns/1ps
module tl_ul_mem_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int          DEPTH_LOG2 = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [1:0]  a_size,
    input  logic [3:0]  a_source,
    input  logic [31:0] a_address,
    input  logic [3:0]  a_mask,
    input  logic [31:0] a_data,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_size,
    output logic [3:0]  d_source,
    output logic        d_denied,
    output logic [31:0] d_data
);

    localparam int          DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [31:0] REGION = 32'd4 << DEPTH_LOG2;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ARITH       = 3'd2;
    localparam logic [2:0] OP_LOGICAL     = 3'd3;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_HINT        = 3'd5;

    localparam logic [2:0] D_ACK      = 3'd0;
    localparam logic [2:0] D_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK = 3'd2;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [3:0]  source;
        logic        denied;
        logic [31:0] data;
    } rsp_t;

    logic [31:0]           mem [0:DEPTH-1];
    rsp_t                  q [0:1];
    logic [1:0]            count;
    logic                  wr_ptr;
    logic                  rd_ptr;

    logic                  push;
    logic                  pop;
    logic [31:0]           offset;
    logic                  hit;
    logic                  misalign;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  op_ok;
    logic                  is_write;
    logic                  is_read;
    logic                  is_atomic;
    logic                  denied;
    logic [2:0]            rsp_op;
    logic [31:0]           old_word;
    logic [31:0]           new_word;
    logic [31:0]           wmask;
    logic                  mem_we;
    rsp_t                  rsp_in;
    rsp_t                  head;

    assign a_ready = (count != 2'd2);
    assign d_valid = (count != 2'd0);
    assign push    = a_valid && a_ready;
    assign pop     = d_valid && d_ready;

    // Offset-based compare avoids overflow of BASE_ADDR + REGION near the top of the map.
    assign offset   = a_address - BASE_ADDR;
    assign hit      = (a_address >= BASE_ADDR) && (offset < REGION);
    assign idx      = offset[DEPTH_LOG2+1:2];
    assign old_word = mem[idx];

    always_comb begin
        case (a_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = a_address[0];
            2'd2:    misalign = |a_address[1:0];
            default: misalign = 1'b1;
        endcase
    end

    always_comb begin
        op_ok     = 1'b0;
        is_write  = 1'b0;
        is_read   = 1'b0;
        is_atomic = 1'b0;
        rsp_op    = D_ACK;
        case (a_opcode)
            OP_PUT_FULL, OP_PUT_PARTIAL: begin
                op_ok    = 1'b1;
                is_write = 1'b1;
            end
            OP_GET: begin
                op_ok   = 1'b1;
                is_read = 1'b1;
                rsp_op  = D_ACK_DATA;
            end
            OP_HINT: begin
                op_ok  = 1'b1;
                rsp_op = D_HINT_ACK;
            end
            OP_ARITH: begin
                rsp_op = D_ACK_DATA;
`ifdef TL_RESP_ATOMICS_EN
                op_ok     = (a_param <= 3'd4);
                is_atomic = 1'b1;
`endif
            end
            OP_LOGICAL: begin
                rsp_op = D_ACK_DATA;
`ifdef TL_RESP_ATOMICS_EN
                op_ok     = (a_param <= 3'd3);
                is_atomic = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign denied = !hit || misalign || !op_ok;

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            wmask[8*b +: 8] = {8{a_mask[b]}};
        end
    end

`ifdef TL_RESP_ATOMICS_EN
    logic [4:0]  lane_sh;
    logic [4:0]  top_sh;
    logic [31:0] old_t;
    logic [31:0] arg_t;
    logic [31:0] res_t;
    logic [31:0] amo_word;

    // Operands are MSB-aligned so one 32-bit compare/add serves all access sizes.
    assign lane_sh = {a_address[1:0], 3'b000};
    always_comb begin
        case (a_size)
            2'd0:    top_sh = 5'd24;
            2'd1:    top_sh = 5'd16;
            default: top_sh = 5'd0;
        endcase
    end
    assign old_t = (old_word >> lane_sh) << top_sh;
    assign arg_t = (a_data >> lane_sh) << top_sh;

    always_comb begin
        case (a_param)
            3'd0:    res_t = ($signed(old_t) < $signed(arg_t)) ? old_t : arg_t;
            3'd1:    res_t = ($signed(old_t) > $signed(arg_t)) ? old_t : arg_t;
            3'd2:    res_t = (old_t < arg_t) ? old_t : arg_t;
            3'd3:    res_t = (old_t > arg_t) ? old_t : arg_t;
            default: res_t = old_t + arg_t;
        endcase
        amo_word = (res_t >> top_sh) << lane_sh;
        if (a_opcode == OP_LOGICAL) begin
            case (a_param)
                3'd0:    amo_word = old_word ^ a_data;
                3'd1:    amo_word = old_word | a_data;
                3'd2:    amo_word = old_word & a_data;
                default: amo_word = a_data;
            endcase
        end
    end

    assign new_word = is_atomic ? amo_word : a_data;
`else
    logic unused_param;
    assign unused_param = ^a_param;
    assign new_word     = a_data;
`endif

    assign mem_we = push && !denied && (is_write || is_atomic);

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[idx] <= (new_word & wmask) | (old_word & ~wmask);
        end
    end

    assign rsp_in.opcode = rsp_op;
    assign rsp_in.size   = a_size;
    assign rsp_in.source = a_source;
    assign rsp_in.denied = denied;
    assign rsp_in.data   = (!denied && (is_read || is_atomic)) ? old_word : 32'd0;

    always_ff @(posedge clock) begin
        if (push) begin
            q[wr_ptr] <= rsp_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Gating on d_valid keeps the D fields at zero during reset and when the queue is empty.
    assign head     = d_valid ? q[rd_ptr] : '0;
    assign d_opcode = head.opcode;
    assign d_size   = head.size;
    assign d_source = head.source;
    assign d_denied = head.denied;
    assign d_data   = head.data;

endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Bench for tl_ul_mem_responder: scoreboard of expected D beats pushed at A acceptance.
`timescale 1ns/1ps
module tb_tl_ul_mem_responder;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int          DL2  = 6;
    localparam logic [31:0] SPAN = 32'd4 << DL2;

    logic        clock;
    logic        reset_n;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [3:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;

    tl_ul_mem_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
        .d_source(d_source), .d_denied(d_denied), .d_data(d_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          pop_cyc_q[$];
    logic [41:0] exp_q[$];
    logic [31:0] mem_m [0:63];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: returns {opcode,size,source,denied,data} and updates mem_m.
    function automatic logic [41:0] model(input logic [2:0] op, input logic [2:0] prm,
                                          input logic [1:0] sz, input logic [3:0] src,
                                          input logic [31:0] addr, input logic [3:0] m,
                                          input logic [31:0] dat);
        logic [31:0] off;
        logic [31:0] old;
        logic [31:0] nw;
        logic [2:0]  rop;
        logic        ok;
        logic        den;
        logic        mis;
        logic [31:0] dout;
        int          ix;
        off  = addr - BASE;
        ix   = int'(off[7:2]);
        mis  = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
        ok   = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd5);
`ifdef TL_RESP_ATOMICS_EN
        ok   = ok || (op == 3'd2 && prm <= 3'd4) || (op == 3'd3 && prm <= 3'd3);
`endif
        den  = (addr < BASE) || (off >= SPAN) || mis || !ok;
        case (op)
            3'd4, 3'd2, 3'd3: rop = 3'd1;
            3'd5:             rop = 3'd2;
            default:          rop = 3'd0;
        endcase
        dout = 32'd0;
        if (!den) begin
            old = mem_m[ix];
            nw  = old;
            case (op)
                3'd0, 3'd1: for (int b = 0; b < 4; b++) if (m[b]) nw[8*b +: 8] = dat[8*b +: 8];
                3'd4:       dout = old;
                3'd2: begin
                    dout = old;
                    if (prm == 3'd4) nw = old + dat;
                end
                default: ;
            endcase
            mem_m[ix] = nw;
        end
        return {rop, sz, src, den, dout};
    endfunction

    // Called just after a rising edge; returns just after the edge that follows acceptance.
    task automatic send(input logic [2:0] op, input logic [2:0] prm, input logic [1:0] sz,
                        input logic [3:0] src, input logic [31:0] addr, input logic [3:0] m,
                        input logic [31:0] dat);
        int budget;
        a_valid = 1'b1; a_opcode = op; a_param = prm; a_size = sz;
        a_source = src; a_address = addr; a_mask = m; a_data = dat;
        budget = 0;
        @(negedge clock);
        while (!a_ready && budget < 50) begin
            budget++;
            @(negedge clock);
        end
        if (!a_ready) chk("a_accept_timeout", {63'd0, a_ready}, 64'd1);
        else begin
            acc_cyc = cyc;
            exp_q.push_back(model(op, prm, sz, src, addr, m, dat));
        end
        @(posedge clock);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            budget++;
            @(negedge clock);
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (reset_n && d_valid && d_ready) begin
            pop_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) chk("unexpected_rsp", {63'd0, d_valid}, 64'd0);
            else chk("rsp", {22'd0, d_opcode, d_size, d_source, d_denied, d_data}, {22'd0, exp_q.pop_front()});
        end
    end

    initial begin
        reset_n = 1'b0; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
        a_source = '0; a_address = '0; a_mask = '0; a_data = '0; d_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_a_ready", {63'd0, a_ready}, 64'd1);
        chk("rst_d_valid", {63'd0, d_valid}, 64'd0);
        chk("rst_d_fields", {22'd0, d_opcode, d_size, d_source, d_denied, d_data}, 64'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Put then Get, each response visible the cycle after acceptance
        send(3'd0, 3'd0, 2'd2, 4'd3, BASE + 32'd4, 4'hF, 32'hDEAD_BEEF);
        chk("lat_put", {63'd0, d_valid}, 64'd1);
        send(3'd4, 3'd0, 2'd2, 4'd3, BASE + 32'd4, 4'hF, 32'd0);
        chk("lat_get", {63'd0, d_valid}, 64'd1);
        wait_drain();

        // Partial write merges one lane
        send(3'd0, 3'd0, 2'd2, 4'd1, BASE + 32'd8, 4'hF, 32'h1122_3344);
        send(3'd1, 3'd0, 2'd0, 4'd2, BASE + 32'd9, 4'b0010, 32'h0000_AB00);
        send(3'd4, 3'd0, 2'd2, 4'd4, BASE + 32'd8, 4'hF, 32'd0);
        wait_drain();

        // Backpressure: queue fills at two, third waits for first pop
        d_ready = 1'b0;
        send(3'd4, 3'd0, 2'd2, 4'd5, BASE + 32'd4, 4'hF, 32'd0);
        send(3'd4, 3'd0, 2'd2, 4'd6, BASE + 32'd8, 4'hF, 32'd0);
        chk("full_a_ready", {63'd0, a_ready}, 64'd0);
        chk("full_d_valid", {63'd0, d_valid}, 64'd1);
        pop_cyc_q.delete();
        fork
            send(3'd4, 3'd0, 2'd2, 4'd7, BASE + 32'd4, 4'hF, 32'd0);
            begin
                repeat (2) @(posedge clock);
                #1;
                d_ready = 1'b1;
            end
        join
        if (pop_cyc_q.size() == 0) chk("first_pop_seen", 64'(pop_cyc_q.size()), 64'd1);
        else chk("third_accept_cycle", 64'(acc_cyc), 64'(pop_cyc_q[0] + 1));
        wait_drain();

        // Denied cases and boundaries
        send(3'd4, 3'd0, 2'd2, 4'd8,  BASE + SPAN, 4'hF, 32'd0);
        send(3'd4, 3'd0, 2'd2, 4'd9,  BASE + 32'd2, 4'hF, 32'd0);
        send(3'd4, 3'd0, 2'd2, 4'd10, BASE - 32'd4, 4'hF, 32'd0);
        send(3'd0, 3'd0, 2'd2, 4'd11, BASE + 32'd6, 4'hF, 32'hFFFF_FFFF);
        send(3'd0, 3'd0, 2'd3, 4'd12, BASE + 32'd8, 4'hF, 32'hFFFF_FFFF);
        send(3'd6, 3'd0, 2'd2, 4'd13, BASE + 32'd4, 4'hF, 32'd0);
        send(3'd5, 3'd0, 2'd2, 4'd14, BASE, 4'hF, 32'd0);
        send(3'd4, 3'd0, 2'd2, 4'd15, BASE + 32'd4, 4'hF, 32'd0);
        send(3'd4, 3'd0, 2'd2, 4'd0,  BASE + 32'd8, 4'hF, 32'd0);
        send(3'd0, 3'd0, 2'd2, 4'd1,  BASE + SPAN - 32'd4, 4'hF, 32'hCAFE_F00D);
        send(3'd4, 3'd0, 2'd2, 4'd2,  BASE + SPAN - 32'd4, 4'hF, 32'd0);
        wait_drain();

        // Atomic ADD (denied when atomics are compiled out)
        send(3'd0, 3'd0, 2'd2, 4'd3, BASE + 32'd20, 4'hF, 32'd5);
        send(3'd2, 3'd4, 2'd2, 4'd4, BASE + 32'd20, 4'hF, 32'd3);
        send(3'd4, 3'd0, 2'd2, 4'd5, BASE + 32'd20, 4'hF, 32'd0);
        wait_drain();

        // Reset with two responses queued
        d_ready = 1'b0;
        send(3'd4, 3'd0, 2'd2, 4'd1, BASE + 32'd4, 4'hF, 32'd0);
        send(3'd4, 3'd0, 2'd2, 4'd2, BASE + 32'd8, 4'hF, 32'd0);
        chk("pre_rst_full", {63'd0, a_ready}, 64'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_a_ready", {63'd0, a_ready}, 64'd1);
        chk("mid_rst_d_valid", {63'd0, d_valid}, 64'd0);
        chk("mid_rst_d_fields", {22'd0, d_opcode, d_size, d_source, d_denied, d_data}, 64'd0);
        exp_q.delete();
        #2;
        reset_n = 1'b1;
        d_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("no_stale", {63'd0, d_valid}, 64'd0);
        end
        @(posedge clock);
        #1;
        send(3'd4, 3'd0, 2'd2, 4'd6, BASE + 32'd8, 4'hF, 32'd0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
